// File: rtl/spatz_xif_offloader.sv
// X-interface offloader towards Spatz: issues core instructions, tracks
// writeback rds in an in-order FIFO + busy mask, routes results to the RF.
//
// Ports (flattened bundles, MSB first):
//   clk_i, rst_ni            clock, async active-low reset
//   offload_valid_i/ready_o  core handshake; offload_instr_i, offload_rs1_i, offload_rs2_i
//   x_issue_valid_o/ready_i  issue handshake
//   x_issue_req_o  [95:0]    {instr, rs[0], rs[1]}
//   x_issue_resp_i [1:0]     {writeback, exc}, sampled on issue handshake
//   x_result_valid_i/ready_o result handshake
//   x_result_i     [33:0]    {data, we, exc}
//   rf_wr_valid_o/ready_i    RF write port; rf_wr_addr_o, rf_wr_data_o
//   illegal_instr_o          pulse: issue rejected with exc
//   protocol_err_o           pulse: result with nothing pending
//   outstanding_o            pending writeback count
module spatz_xif_offloader #(
  parameter int unsigned NrOutstanding = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        offload_valid_i,
  output logic        offload_ready_o,
  input  logic [31:0] offload_instr_i,
  input  logic [31:0] offload_rs1_i,
  input  logic [31:0] offload_rs2_i,
  output logic        x_issue_valid_o,
  input  logic        x_issue_ready_i,
  output logic [95:0] x_issue_req_o,
  input  logic [1:0]  x_issue_resp_i,
  input  logic        x_result_valid_i,
  output logic        x_result_ready_o,
  input  logic [33:0] x_result_i,
  output logic        rf_wr_valid_o,
  input  logic        rf_wr_ready_i,
  output logic [4:0]  rf_wr_addr_o,
  output logic [31:0] rf_wr_data_o,
  output logic        illegal_instr_o,
  output logic        protocol_err_o,
  output logic [$clog2(NrOutstanding+1)-1:0] outstanding_o
);

  localparam int unsigned CntW = $clog2(NrOutstanding + 1);
  localparam int unsigned PtrW = $clog2(NrOutstanding);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e            state_q, state_d;
  logic [31:0]       instr_q, rs1_q, rs2_q;
  logic [4:0]        fifo_q [NrOutstanding];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [31:0]       busy_q;
  logic              illegal_q, proto_q;

  logic [4:0] in_rd, in_rs1, in_rs2, iss_rd, res_rd;
  logic       full, empty, hazard;
  logic       offload_hs, issue_hs, res_hs;
  logic       resp_wb, resp_exc, res_we, res_exc;
  logic       bypass, push, pop, perr;

  assign in_rd  = offload_instr_i[11:7];
  assign in_rs1 = offload_instr_i[19:15];
  assign in_rs2 = offload_instr_i[24:20];
  assign iss_rd = instr_q[11:7];

  assign resp_wb  = x_issue_resp_i[1];
  assign resp_exc = x_issue_resp_i[0];
  assign res_we   = x_result_i[1];
  assign res_exc  = x_result_i[0];

  assign full   = count_q == CntW'(NrOutstanding);
  assign empty  = count_q == '0;
  assign hazard = busy_q[in_rs1] | busy_q[in_rs2] | busy_q[in_rd];

  always_comb begin
    state_d         = state_q;
    offload_ready_o = 1'b0;
    x_issue_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        offload_ready_o = ~full & ~hazard;
        if (offload_valid_i && offload_ready_o) state_d = ISSUE;
      end
      ISSUE: begin
        x_issue_valid_o = 1'b1;
        if (x_issue_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign offload_hs = offload_valid_i & offload_ready_o;
  assign issue_hs   = x_issue_valid_o & x_issue_ready_i;
  assign x_result_ready_o = rf_wr_ready_i;
  assign res_hs     = x_result_valid_i & x_result_ready_o;

  // A result racing its own issue into an empty FIFO binds to the issuing rd.
  assign bypass = res_hs & issue_hs & resp_wb & ~resp_exc & empty;
  assign push   = issue_hs & resp_wb & ~resp_exc & ~bypass;
  assign pop    = res_hs & ~empty;
  assign perr   = res_hs & empty & ~bypass;

  assign res_rd        = bypass ? iss_rd : fifo_q[rd_ptr_q];
  assign rf_wr_valid_o = (pop | bypass) & res_we & (res_rd != 5'd0) & ~res_exc;
  assign rf_wr_addr_o  = res_rd;
  assign rf_wr_data_o  = x_result_i[33:2];

  assign x_issue_req_o   = {instr_q, rs1_q, rs2_q};
  assign illegal_instr_o = illegal_q;
  assign protocol_err_o  = proto_q;
  assign outstanding_o   = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else if (offload_hs) begin
      instr_q <= offload_instr_i;
      rs1_q   <= offload_rs1_i;
      rs2_q   <= offload_rs2_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NrOutstanding); i++) fifo_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      busy_q    <= '0;
      illegal_q <= 1'b0;
      proto_q   <= 1'b0;
    end else begin
      illegal_q <= issue_hs & resp_exc;
      proto_q   <= perr;
      if (push) begin
        fifo_q[wr_ptr_q] <= iss_rd;
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
      // Clear first so a same-cycle set of the same rd wins.
      begin
        logic [31:0] b;
        b = busy_q;
        if (pop)  b[fifo_q[rd_ptr_q]] = 1'b0;
        if (push) b[iss_rd] = 1'b1;
        b[0] = 1'b0;
        busy_q <= b;
      end
    end
  end

endmodule

// File: tb/tb_spatz_xif_offloader.sv
// Directed testbench for spatz_xif_offloader.
// Drives after posedge+#1, checks away from the clock edge.
module tb_spatz_xif_offloader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        offload_valid;
  logic        offload_ready;
  logic [31:0] offload_instr, offload_rs1, offload_rs2;
  logic        x_issue_valid, x_issue_ready;
  logic [95:0] x_issue_req;
  logic [1:0]  x_issue_resp;
  logic        x_result_valid, x_result_ready;
  logic [33:0] x_result;
  logic        rf_wr_valid, rf_wr_ready;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        illegal_instr, protocol_err;
  logic [2:0]  outstanding;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spatz_xif_offloader #(.NrOutstanding(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .offload_valid_i(offload_valid), .offload_ready_o(offload_ready),
    .offload_instr_i(offload_instr), .offload_rs1_i(offload_rs1),
    .offload_rs2_i(offload_rs2),
    .x_issue_valid_o(x_issue_valid), .x_issue_ready_i(x_issue_ready),
    .x_issue_req_o(x_issue_req), .x_issue_resp_i(x_issue_resp),
    .x_result_valid_i(x_result_valid), .x_result_ready_o(x_result_ready),
    .x_result_i(x_result),
    .rf_wr_valid_o(rf_wr_valid), .rf_wr_ready_i(rf_wr_ready),
    .rf_wr_addr_o(rf_wr_addr), .rf_wr_data_o(rf_wr_data),
    .illegal_instr_o(illegal_instr), .protocol_err_o(protocol_err),
    .outstanding_o(outstanding)
  );

  function automatic logic [31:0] vop(input logic [4:0] rd,
                                      input logic [4:0] rs1,
                                      input logic [4:0] rs2);
    return {7'h00, rs2, rs1, 3'b000, rd, 7'h57};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    offload_valid  = 1'b0;
    offload_instr  = '0;
    offload_rs1    = '0;
    offload_rs2    = '0;
    x_issue_ready  = 1'b0;
    x_issue_resp   = '0;
    x_result_valid = 1'b0;
    x_result       = '0;
    rf_wr_ready    = 1'b1;
  endtask

  // Offload one instruction and complete its issue with the given response.
  task automatic issue_one(input logic [31:0] instr, input logic wb,
                           input logic exc);
    bit ok = 0;
    offload_valid = 1'b1;
    offload_instr = instr;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (offload_ready) begin ok = 1; break; end
      step();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL issue_accept_timeout instr=%h got ready=0 want 1", instr);
    end
    step();
    offload_valid = 1'b0;
    x_issue_ready = 1'b1;
    x_issue_resp  = {wb, exc};
    step();
    x_issue_ready = 1'b0;
    x_issue_resp  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #12;
    checks++;
    if (x_issue_valid !== 1'b0 || x_issue_req !== '0 || outstanding !== 3'd0
        || illegal_instr !== 1'b0 || protocol_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got v=%b req=%h cnt=%0d ill=%b perr=%b want 0",
               x_issue_valid, x_issue_req, outstanding, illegal_instr, protocol_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (offload_ready !== 1'b1 || rf_wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got rdy=%b rfv=%b want 1 0", offload_ready, rf_wr_valid);
    end
  endtask

  task automatic test_csrr_bypass();
    offload_valid = 1'b1;
    offload_instr = {12'hC20, 5'd0, 3'b010, 5'd5, 7'h73};
    #1;
    checks++;
    if (offload_ready !== 1'b1) begin
      errors++;
      $display("FAIL csrr_accept got %b want 1", offload_ready);
    end
    step();
    offload_valid  = 1'b0;
    x_issue_ready  = 1'b1;
    x_issue_resp   = 2'b10;
    x_result_valid = 1'b1;
    x_result       = {32'h10, 1'b1, 1'b0};
    #1;
    checks++;
    if (x_issue_valid !== 1'b1 || rf_wr_valid !== 1'b1 || rf_wr_addr !== 5'd5
        || rf_wr_data !== 32'h10) begin
      errors++;
      $display("FAIL csrr_bypass got v=%b rfv=%b a=%0d d=%h want 1 1 5 10",
               x_issue_valid, rf_wr_valid, rf_wr_addr, rf_wr_data);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (outstanding !== 3'd0 || protocol_err !== 1'b0 || offload_ready !== 1'b1) begin
      errors++;
      $display("FAIL csrr_after got cnt=%0d perr=%b rdy=%b want 0 0 1",
               outstanding, protocol_err, offload_ready);
    end
  endtask

  task automatic test_issue_stall();
    logic [95:0] exp_req;
    exp_req = {vop(5'd6, 5'd1, 5'd2), 32'hAAAA_0001, 32'hBBBB_0002};
    offload_valid = 1'b1;
    offload_instr = vop(5'd6, 5'd1, 5'd2);
    offload_rs1   = 32'hAAAA_0001;
    offload_rs2   = 32'hBBBB_0002;
    step();
    offload_instr = vop(5'd7, 5'd0, 5'd0);
    offload_rs1   = '0;
    offload_rs2   = '0;
    for (int i = 0; i < 4; i++) begin
      x_issue_ready = (i == 3);
      #1;
      checks++;
      if (x_issue_valid !== 1'b1 || x_issue_req !== exp_req || offload_ready !== 1'b0) begin
        errors++;
        $display("FAIL issue_hold_%0d got v=%b req=%h rdy=%b want 1 %h 0",
                 i, x_issue_valid, x_issue_req, offload_ready, exp_req);
      end
      step();
    end
    idle_inputs();
    #1;
    checks++;
    if (x_issue_valid !== 1'b0 || outstanding !== 3'd0) begin
      errors++;
      $display("FAIL issue_done got v=%b cnt=%0d want 0 0", x_issue_valid, outstanding);
    end
  endtask

  task automatic test_full();
    for (int r = 1; r <= 4; r++) issue_one(vop(5'(r), 5'd0, 5'd0), 1'b1, 1'b0);
    offload_valid = 1'b1;
    offload_instr = vop(5'd7, 5'd0, 5'd0);
    #1;
    checks++;
    if (outstanding !== 3'd4 || offload_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_block got cnt=%0d rdy=%b want 4 0", outstanding, offload_ready);
    end
    x_result_valid = 1'b1;
    x_result       = {32'hA1, 1'b1, 1'b0};
    #1;
    checks++;
    if (rf_wr_valid !== 1'b1 || rf_wr_addr !== 5'd1 || rf_wr_data !== 32'hA1) begin
      errors++;
      $display("FAIL full_pop got v=%b a=%0d d=%h want 1 1 a1",
               rf_wr_valid, rf_wr_addr, rf_wr_data);
    end
    step();
    x_result_valid = 1'b0;
    #1;
    checks++;
    if (outstanding !== 3'd3 || offload_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_release got cnt=%0d rdy=%b want 3 1", outstanding, offload_ready);
    end
    offload_valid = 1'b0;
    for (int r = 2; r <= 4; r++) begin
      x_result_valid = 1'b1;
      x_result       = {32'(r * 3), 1'b1, 1'b0};
      #1;
      checks++;
      if (rf_wr_valid !== 1'b1 || rf_wr_addr !== 5'(r) || rf_wr_data !== 32'(r * 3)) begin
        errors++;
        $display("FAIL drain_%0d got v=%b a=%0d d=%h want 1 %0d %h",
                 r, rf_wr_valid, rf_wr_addr, rf_wr_data, r, r * 3);
      end
      step();
    end
    idle_inputs();
    #1;
    checks++;
    if (outstanding !== 3'd0) begin
      errors++;
      $display("FAIL drain_count got %0d want 0", outstanding);
    end
  endtask

  task automatic test_raw_hazard();
    issue_one(vop(5'd5, 5'd0, 5'd0), 1'b1, 1'b0);
    offload_valid = 1'b1;
    offload_instr = vop(5'd8, 5'd5, 5'd0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (offload_ready !== 1'b0) begin
        errors++;
        $display("FAIL raw_stall_%0d got rdy=%b want 0", i, offload_ready);
      end
      step();
    end
    x_result_valid = 1'b1;
    x_result       = {32'h55, 1'b1, 1'b0};
    #1;
    checks++;
    if (offload_ready !== 1'b0 || rf_wr_valid !== 1'b1 || rf_wr_addr !== 5'd5) begin
      errors++;
      $display("FAIL raw_result got rdy=%b rfv=%b a=%0d want 0 1 5",
               offload_ready, rf_wr_valid, rf_wr_addr);
    end
    step();
    x_result_valid = 1'b0;
    #1;
    checks++;
    if (offload_ready !== 1'b1) begin
      errors++;
      $display("FAIL raw_release got rdy=%b want 1", offload_ready);
    end
    step();
    offload_valid = 1'b0;
    x_issue_ready = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic test_exc();
    issue_one(vop(5'd9, 5'd0, 5'd0), 1'b1, 1'b1);
    checks++;
    if (illegal_instr !== 1'b1 || outstanding !== 3'd0 || rf_wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL exc_pulse got ill=%b cnt=%0d rfv=%b want 1 0 0",
               illegal_instr, outstanding, rf_wr_valid);
    end
    step();
    checks++;
    if (illegal_instr !== 1'b0 || offload_ready !== 1'b1) begin
      errors++;
      $display("FAIL exc_end got ill=%b rdy=%b want 0 1", illegal_instr, offload_ready);
    end
  endtask

  task automatic test_protocol_err();
    x_result_valid = 1'b1;
    x_result       = {32'hDEAD, 1'b1, 1'b0};
    #1;
    checks++;
    if (rf_wr_valid !== 1'b0 || protocol_err !== 1'b0) begin
      errors++;
      $display("FAIL perr_same got rfv=%b perr=%b want 0 0", rf_wr_valid, protocol_err);
    end
    step();
    x_result_valid = 1'b0;
    checks++;
    if (protocol_err !== 1'b1 || outstanding !== 3'd0) begin
      errors++;
      $display("FAIL perr_pulse got perr=%b cnt=%0d want 1 0", protocol_err, outstanding);
    end
    step();
    checks++;
    if (protocol_err !== 1'b0) begin
      errors++;
      $display("FAIL perr_end got %b want 0", protocol_err);
    end
  endtask

  task automatic test_rd_zero();
    issue_one(vop(5'd0, 5'd0, 5'd0), 1'b1, 1'b0);
    checks++;
    if (outstanding !== 3'd1) begin
      errors++;
      $display("FAIL rd0_push got cnt=%0d want 1", outstanding);
    end
    x_result_valid = 1'b1;
    x_result       = {32'h77, 1'b1, 1'b0};
    #1;
    checks++;
    if (rf_wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd0_nowrite got rfv=%b want 0", rf_wr_valid);
    end
    step();
    x_result_valid = 1'b0;
    checks++;
    if (outstanding !== 3'd0 || protocol_err !== 1'b0) begin
      errors++;
      $display("FAIL rd0_pop got cnt=%0d perr=%b want 0 0", outstanding, protocol_err);
    end
  endtask

  initial begin
    test_reset();
    test_csrr_bypass();
    test_issue_stall();
    test_full();
    test_raw_hazard();
    test_exc();
    test_protocol_err();
    test_rd_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
